// File: rtl/jtopl_csr_wr.sv
// jtopl_csr_wr: host register write sequencer for the OPL operator shift store.
// A host write is latched, then released to the circular register store as a
// three-stage strobe sequence (stage I, II, IV) aligned to the target operator slot.
// Optional feature: define JTOPL_CSR_WR_WAV_EN to decode field 7 (waveform select).
module jtopl_csr_wr #(
    parameter int unsigned LEN = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic [7:0] din,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV,
    output logic [4:0] slot
);

    typedef enum logic [1:0] {StIdle, StWait, StSeq} state_e;

    localparam logic [4:0] SlotLast = 5'(LEN - 1);

    state_e     state_q;
    logic [4:0] slot_q;
    logic [4:0] tgt_q;
    logic [1:0] stage_q;
    logic       busy_q;
    logic [7:0] din_q;
    // One bit per field: {wav, sl_rr, ar_dr, ksl_tl, mult}
    logic [4:0] up_q;

    logic [4:0] fld_sel;
    logic       fld_valid;
    logic       op_valid;
    logic [4:0] tgt;

    // Decode the field select and target slot of the incoming host address
    always_comb begin
        fld_sel = 5'b0;
        case (addr[7:5])
            3'd1:    fld_sel[0] = 1'b1;
            3'd2:    fld_sel[1] = 1'b1;
            3'd3:    fld_sel[2] = 1'b1;
            3'd4:    fld_sel[3] = 1'b1;
`ifdef JTOPL_CSR_WR_WAV_EN
            3'd7:    fld_sel[4] = 1'b1;
`endif
            default: fld_sel = 5'b0;
        endcase
        fld_valid = |fld_sel;
        // Three groups of six operators; op codes 6,7 and group 3 do not exist
        op_valid  = (addr[2:0] <= 3'd5) && (addr[4:3] != 2'd3);
        tgt       = ({3'b0, addr[4:3]} * 5'd6) + {2'b0, addr[2:0]};
    end

    // Slot counter and write sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            slot_q  <= 5'd0;
            tgt_q   <= 5'd0;
            stage_q <= 2'd0;
            busy_q  <= 1'b0;
            din_q   <= 8'd0;
            up_q    <= 5'd0;
        end else begin
            if (cen) begin
                slot_q <= (slot_q == SlotLast) ? 5'd0 : slot_q + 5'd1;
            end
            unique case (state_q)
                StIdle: begin
                    // Writes are sampled on every edge; invalid ones are dropped silently
                    if (wr && fld_valid && op_valid) begin
                        din_q   <= wdata;
                        up_q    <= fld_sel;
                        tgt_q   <= tgt;
                        busy_q  <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Matching only starts after the latch edge, so a write that
                    // arrives on its own slot waits a whole revolution
                    if (cen && (slot_q == tgt_q)) begin
                        stage_q <= 2'd0;
                        state_q <= StSeq;
                    end
                end
                StSeq: begin
                    if (cen) begin
                        if (stage_q == 2'd2) begin
                            busy_q  <= 1'b0;
                            up_q    <= 5'd0;
                            state_q <= StIdle;
                        end else begin
                            stage_q <= stage_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stage strobes are qualified by cen so they are one clk wide and never
    // fire in a frozen cycle; rst gating keeps them quiet during reset
    always_comb begin
        update_op_I  = rst && cen && (state_q == StWait) && (slot_q == tgt_q);
        update_op_II = rst && cen && (state_q == StSeq) && (stage_q == 2'd0);
        update_op_IV = rst && cen && (state_q == StSeq) && (stage_q == 2'd2);
    end

    assign busy      = busy_q;
    assign din       = din_q;
    assign slot      = slot_q;
    assign up_mult   = up_q[0];
    assign up_ksl_tl = up_q[1];
    assign up_ar_dr  = up_q[2];
    assign up_sl_rr  = up_q[3];
`ifdef JTOPL_CSR_WR_WAV_EN
    assign up_wav    = up_q[4];
`else
    // Field 7 never decodes, so this bit stays at zero
    logic unused_wav;
    assign unused_wav = up_q[4];
    assign up_wav     = 1'b0;
`endif

endmodule

// File: doc/jtopl_csr_wr.md
JTOPL_CSR_WR -- requirements
Module: jtopl_csr_wr

Interface
REQ-001 Parameter LEN, default 18: number of operator slots in one circular revolution; the slot counter wraps at this value.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low: state clears on a clk rising edge while rst=0.
REQ-004 cen  input  1  clock enable; slot counter and update sequencing advance only on clk edges with cen=1.
REQ-005 wr  input  1  host write request, sampled on any clk edge (cen not required).
REQ-006 addr  input  8  host register address: addr[7:5] selects the field, addr[4:0] selects the operator.
REQ-007 wdata  input  8  host write data.
REQ-008 busy  output  1  high while a write is pending.
REQ-009 din  output  8  latched write data presented to the register shift store.
REQ-010 up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav  output  1 each  field select levels.
REQ-011 update_op_I, update_op_II, update_op_IV  output  1 each  per-stage slot-match strobes.
REQ-012 slot  output  5  current slot counter value, 0..LEN-1.

Function
REQ-013 The slot counter SHALL increment on every clk edge with cen=1 and wrap from LEN-1 to 0.
REQ-014 The field decode from addr[7:5] SHALL be 1=mult, 2=ksl_tl, 3=ar_dr, 4=sl_rr, 7=wav; any other code is an invalid field.
REQ-015 The target slot SHALL be addr[4:3]*6+addr[2:0]; addr[2:0]>5 or addr[4:3]=3 is an invalid operator.
REQ-016 The FSM SHALL have the states IDLE, WAIT and SEQ.
REQ-017 In IDLE, wr=1 with a valid field and a valid operator SHALL latch wdata, the field and the target slot, and SHALL enter WAIT with busy=1 from the next cycle.
REQ-018 In IDLE, wr=1 with an invalid field or an invalid operator SHALL be discarded: no strobe is produced and busy stays 0.
REQ-019 wr=1 while busy=1 SHALL be ignored; the pending write is unaffected.
REQ-020 In WAIT and SEQ, din SHALL hold the latched data and exactly the selected up_* SHALL be held high; in IDLE all up_* SHALL be 0.
REQ-021 Slot matching SHALL begin on the first cen edge after the write is latched; a match at the latch edge itself is not taken and costs a full revolution.
REQ-022 In WAIT, in the clk cycle with cen=1 and slot equal to the target, update_op_I SHALL be high for exactly that cycle, and the FSM SHALL enter SEQ.
REQ-023 update_op_II SHALL pulse on the 1st cen cycle after update_op_I, and update_op_IV SHALL pulse on the 3rd cen cycle after update_op_I; each pulse lasts one clk cycle.
REQ-024 After the update_op_IV cycle the FSM SHALL return to IDLE, and busy SHALL fall on the next clk edge.
REQ-025 Worst-case latency from wr to busy low SHALL be LEN+3 cen cycles plus one clk cycle.
REQ-026 With cen=0 the slot counter, the stage position and all strobes SHALL freeze; update_op_* SHALL never be high while cen=0.

Reset
REQ-027 rst=0 SHALL set: slot=0, FSM=IDLE, busy=0, din=0, all up_* =0, all update_op_* =0.
REQ-028 rst=0 during WAIT or SEQ SHALL abort the pending write with no further strobes.

Configuration
REQ-029 Macro JTOPL_CSR_WR_WAV_EN defined: field 7 (0xE0-0xF5) SHALL be decoded and SHALL assert up_wav.
REQ-030 Macro JTOPL_CSR_WR_WAV_EN undefined: up_wav SHALL be constant 0 and field 7 SHALL be treated as an invalid field.

Verification
REQ-031 Reset, cen=1 continuously, wr addr=0x20 wdata=0x5A at slot=2 -> busy=1; up_mult=1, din=0x5A; update_op_I when slot=0 (next revolution), update_op_II at slot=1, update_op_IV at slot=3, then busy=0.
REQ-032 wr addr=0x4D (group 1, op 5, target 11) wdata=0x3F at slot=11 -> no match at that edge; update_op_I at slot=11 after 18 cen cycles.
REQ-033 wr addr=0x26 and wr addr=0xA0 -> discarded, busy stays 0, no strobes.
REQ-034 A second wr addr=0x60 while busy -> ignored; only the first write's strobes and data appear.
REQ-035 cen every 4th clk -> strobes occur only in cen cycles, one clk wide; rst=0 asserted in SEQ after update_op_II -> no update_op_IV, all outputs return to their reset values.
REQ-036 wr addr=0xE3 -> with JTOPL_CSR_WR_WAV_EN: up_wav=1 and the strobe sequence at slot 3; without: discarded.
